// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the MEM-stage data-memory interface. Takes one load or
//   store at a time and holds it for WAIT_STATES wait cycles. It then performs
//   the access on an internal word-addressed RAM and returns a one-cycle
//   response. A misaligned or out-of-range byte address gives an error
//   response with the same timing as a good access.
//
// Handshake: a request is accepted on a rising edge where
//   req_valid & req_ready are both high. req_ready is high only in IDLE.
//   resp_valid is a single-cycle pulse, and resp_rdata/resp_err are only
//   meaningful while it is high. req_* inputs are sampled only at accept;
//   changes at any other time are ignored.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   req_valid  in   MEM stage presents a request
//   req_we     in   1 = store, 0 = load
//   req_addr   in   32-bit byte address
//   req_wdata  in   store data
//   req_ready  out  request can be accepted this cycle (IDLE)
//   resp_valid out  one-cycle completion pulse
//   resp_rdata out  load data (0 for stores and errors)
//   resp_err   out  misaligned / out-of-range, qualified by resp_valid
//   stall      out  holds the pipeline while a request is outstanding
//   dbg_state  out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module data_mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                accept;
  logic                perform;
  logic                acc_we_d;
  logic [31:0]         acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_d;
  logic                acc_err_d;
  logic [ADDR_W-1:0]   acc_idx_d;
  logic [DATA_W-1:0]   rdata_d;

  assign accept = req_valid && (state_q == S_IDLE);

  // With wait states the access happens on the last WAIT cycle. Without them
  // it happens on the accept edge itself, straight from the request inputs.
  assign perform = HAS_WAIT ? ((state_q == S_WAIT) && (cnt_q == 4'd0)) : accept;

  always_comb begin
    acc_we_d    = we_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we_d    = req_we;
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
    end
    acc_err_d = (acc_addr_d[1:0] != 2'b00) || (acc_addr_d[31:ADDR_W+2] != '0);
    acc_idx_d = acc_addr_d[ADDR_W+1:2];
    rdata_d   = (acc_we_d || acc_err_d) ? '0 : mem[acc_idx_d];
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= perform;
      resp_rdata_q <= perform ? rdata_d : '0;
      resp_err_q   <= perform ? acc_err_d : 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            state_q <= HAS_WAIT ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM is not reset. The RESET_N gate stops a zero-wait build from writing
  // while reset is held low.
  always_ff @(posedge CLOCK_50) begin
    if (RESET_N && perform && acc_we_d && !acc_err_d)
      mem[acc_idx_d] <= acc_wdata_d;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = req_valid && !resp_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: WAIT_STATES = 2
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  // DUT B: WAIT_STATES = 0
  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_stall;
  logic [31:0] b_resp_rdata;
  logic [1:0]  b_dbg_state;

  data_mem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_STATES(2)) u_dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .dbg_state(dbg_state)
  );

  data_mem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .stall(b_stall), .dbg_state(b_dbg_state)
  );

  // ---------------- driver: one full request on DUT A ----------------
  // Holds req_valid until the response and checks stall in every cycle.
  // It also checks that the response lands 3 cycles after the accept cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        total++; if (cyc !== 3) begin bad++; $display("FAIL %s latency got=%0d exp=3", nm, cyc); end
        total++; if (resp_rdata !== exp_rd) begin bad++; $display("FAIL %s rdata got=%h exp=%h", nm, resp_rdata, exp_rd); end
        total++; if (resp_err !== exp_err) begin bad++; $display("FAIL %s err got=%b exp=%b", nm, resp_err, exp_err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s stall_resp got=%b exp=0", nm, stall); end
      end else begin
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s stall_wait cyc=%0d got=%b exp=1", nm, cyc, stall); end
        cyc++;
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL %s timeout got=none exp=resp_valid", nm); end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", resp_err); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    do_req(1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, "store_08");
    do_req(1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, "load_08");
  endtask

  task automatic test_errors();
    do_req(1'b0, 32'h06, 32'h0, 32'h0, 1'b1, "load_misaligned");
    do_req(1'b1, 32'h00, 32'hA5A50001, 32'h0, 1'b0, "store_00");
    // 0x81 and 0x80 both map to word 0 if the range check were missing
    do_req(1'b1, 32'h81, 32'hFFFFFFFF, 32'h0, 1'b1, "store_oor_81");
    do_req(1'b1, 32'h80, 32'h77777777, 32'h0, 1'b1, "store_oor_80");
    do_req(1'b1, 32'h8000_0000, 32'h66666666, 32'h0, 1'b1, "store_oor_msb");
    do_req(1'b0, 32'h00, 32'h0, 32'hA5A50001, 1'b0, "load_00_unchanged");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] addrs[3];
    int pulses;
    addrs[0] = 32'h0C; addrs[1] = 32'h10; addrs[2] = 32'h14;
    do_req(1'b1, 32'h0C, 32'h0000_C0C0, 32'h0, 1'b0, "pre_0C");
    do_req(1'b1, 32'h10, 32'hCAFE_0010, 32'h0, 1'b0, "pre_10");
    do_req(1'b1, 32'h14, 32'h1414_1414, 32'h0, 1'b0, "pre_14");
    exp_q.push_back(32'h0000_C0C0);
    exp_q.push_back(32'hCAFE_0010);
    exp_q.push_back(32'h1414_1414);
    pulses = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++; if (req_ready !== (c % 4 == 0)) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, (c % 4 == 0)); end
      total++; if (stall !== (c % 4 != 3)) begin bad++; $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall, (c % 4 != 3)); end
      total++; if (resp_valid !== (c % 4 == 3)) begin bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, resp_valid, (c % 4 == 3)); end
      if (resp_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra c=%0d got=pulse exp=none", c);
        end else begin
          total++; if (resp_rdata !== exp_q[0]) begin bad++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, resp_rdata, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (c % 4 == 3) begin
        if (c == 11) req_valid = 1'b0;
        else         req_addr  = addrs[(c + 1) / 4];
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
  endtask

  task automatic test_latch();
    do_req(1'b1, 32'h1C, 32'h0000_3333, 32'h0, 1'b0, "pre_1C");
    // store 0x1111 @0x18, then corrupt the inputs during WAIT
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'h0000_1111;
    @(negedge clk);
    @(negedge clk);
    req_addr = 32'h1C; req_wdata = 32'h0000_2222; req_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL latch_st_valid got=%b exp=1", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL latch_st_rdata got=%h exp=0", resp_rdata); end
    @(posedge clk); #1; req_valid = 1'b0;
    do_req(1'b0, 32'h18, 32'h0, 32'h0000_1111, 1'b0, "latch_load_18");
    do_req(1'b0, 32'h1C, 32'h0, 32'h0000_3333, 1'b0, "latch_load_1C");
    // load @0x08 whose address turns misaligned during WAIT
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08;
    @(negedge clk);
    @(negedge clk);
    req_addr = 32'h06; req_we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (resp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL latch_ld_rdata got=%h exp=deadbeef", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL latch_ld_err got=%b exp=0", resp_err); end
    @(posedge clk); #1; req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL rmid_in_wait got=%0d exp=1", dbg_state); end
    rst_n = 1'b0;
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", dbg_state); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_resp got=%0d exp=0", pulses); end
    do_req(1'b0, 32'h10, 32'h0, 32'hCAFE_0010, 1'b0, "rmid_load_10");
  endtask

  task automatic test_zero_wait();
    logic        we_v[2];
    logic [31:0] rd_v[2];
    int cyc;
    int stall_cyc;
    bit seen;
    we_v[0] = 1'b1; rd_v[0] = 32'h0;
    we_v[1] = 1'b0; rd_v[1] = 32'h0BAD_F00D;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      b_req_valid = 1'b1; b_req_we = we_v[t]; b_req_addr = 32'h04; b_req_wdata = 32'h0BAD_F00D;
      cyc = 0; stall_cyc = 0; seen = 0;
      while (!seen && cyc < 10) begin
        @(negedge clk);
        if (b_stall) stall_cyc++;
        if (b_resp_valid) seen = 1;
        else cyc++;
      end
      total++; if (!seen || cyc !== 1) begin bad++; $display("FAIL zw_latency t=%0d got=%0d exp=1", t, cyc); end
      total++; if (stall_cyc !== 1) begin bad++; $display("FAIL zw_stall t=%0d got=%0d exp=1", t, stall_cyc); end
      total++; if (b_resp_rdata !== rd_v[t]) begin bad++; $display("FAIL zw_rdata t=%0d got=%h exp=%h", t, b_resp_rdata, rd_v[t]); end
      total++; if (b_resp_err !== 1'b0) begin bad++; $display("FAIL zw_err t=%0d got=%b exp=0", t, b_resp_err); end
      @(posedge clk); #1;
      b_req_valid = 1'b0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_latch();
    test_reset_mid();
    test_zero_wait();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
